// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master controller.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ACK1, WDATA, ACK2, RDATA, MACK, STOP
   } state_t;

   typedef logic [1:0] quarter_t;

   localparam logic     I2C_ACK = 1'b0;
   localparam logic     I2C_RD  = 1'b1;

   localparam quarter_t Q0 = 2'd0;
   localparam quarter_t Q1 = 2'd1;
   localparam quarter_t Q2 = 2'd2;
   localparam quarter_t Q3 = 2'd3;

   // SCL is high in the middle two quarters of every data/ack bit.
   function automatic logic scl_level(input quarter_t q);
      return (q == Q1) || (q == Q2);
   endfunction

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// Command/response handshake plus the open-drain I2C pins of the master.
// cmd transfers on the cycle where cmd_valid && cmd_ready are both high; cmd_ready
// is high only while the controller is idle and does not depend on cmd_valid.
interface i2c_master_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [6:0] cmd_addr;
   logic       cmd_rw;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_nack;
   logic       busy;
   logic       scl_o;
   logic       sda_o;
   logic       sda_oe;
   logic       sda_i;

   modport master (
      input  cmd_valid, cmd_addr, cmd_rw, cmd_wdata, sda_i,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_nack, busy, scl_o, sda_o, sda_oe
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_rw, cmd_wdata, sda_i,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack, busy, scl_o, sda_o, sda_oe
   );
endinterface

// File: rtl/i2c_clk_gen.sv
// Quarter-bit timebase: one quarter_tick every CLK_DIV clocks, held at Q0 while cleared.
module i2c_clk_gen
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     clear,
   output logic     quarter_tick,
   output quarter_t quarter
);

   logic [7:0] cnt;

   assign quarter_tick = !clear && (cnt == 8'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt     <= '0;
         quarter <= Q0;
      end else if (quarter_tick) begin
         cnt     <= '0;
         quarter <= quarter + 2'd1;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, {addr,rw}, ack, one data byte, ack/master-nack, STOP.
module i2c_master_ctrl
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                clk,
   input  logic                rst,
   i2c_master_ctrl_if.master   bus,
   output state_t              dbg_state
);

   state_t     state, state_nx;
   quarter_t   quarter;
   logic       quarter_tick;
   logic       end_slot;
   logic       accept;
   logic       sample_stb;
   logic [2:0] bit_cnt;
   logic [7:0] sr;
   logic [7:0] wdata_q;
   logic       rw_q;
   logic       nack_q;
   logic       busy_q;
   logic       rsp_valid_q;
   logic [7:0] rsp_rdata_q;
   logic       rsp_nack_q;
   logic       scl, sda_drv, sda_en;

   i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk          (clk),
      .rst          (rst),
      .clear        (state == IDLE),
      .quarter_tick (quarter_tick),
      .quarter      (quarter)
   );

   assign end_slot = quarter_tick && (quarter == Q3);
   assign accept   = bus.cmd_valid && (state == IDLE);

   always_comb begin
      state_nx = state;
      scl      = 1'b1;
      sda_drv  = 1'b1;
      sda_en   = 1'b0;
      case (state)
         IDLE:  if (accept) state_nx = START;
         START: begin
            sda_en  = 1'b1;
            sda_drv = !quarter[1];
            if (end_slot) state_nx = ADDR;
         end
         ADDR, WDATA: begin
            scl     = scl_level(quarter);
            sda_en  = 1'b1;
            sda_drv = sr[7];
            if (end_slot && bit_cnt == 3'd7) state_nx = (state == ADDR) ? ACK1 : ACK2;
         end
         ACK1: begin
            scl = scl_level(quarter);
            if (end_slot) state_nx = nack_q ? STOP : ((rw_q == I2C_RD) ? RDATA : WDATA);
         end
         ACK2, MACK: begin
            scl = scl_level(quarter);
            if (end_slot) state_nx = STOP;
         end
         RDATA: begin
            scl = scl_level(quarter);
            if (end_slot && bit_cnt == 3'd7) state_nx = MACK;
         end
         STOP: begin
            // SDA low through the SCL rise, then released high: the STOP edge.
            scl     = (quarter != Q0);
            sda_en  = !quarter[1];
            sda_drv = 1'b0;
            if (end_slot) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sample_stb  <= 1'b0;
         bit_cnt     <= '0;
         sr          <= '0;
         wdata_q     <= '0;
         rw_q        <= 1'b0;
         nack_q      <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_nack_q  <= 1'b0;
      end else begin
         state       <= state_nx;
         // Strobe lands on the first clock of Q2, mid SCL-high.
         sample_stb  <= quarter_tick && (quarter == Q1);
         rsp_valid_q <= 1'b0;
         if (accept) begin
            sr      <= {bus.cmd_addr, bus.cmd_rw};
            wdata_q <= bus.cmd_wdata;
            rw_q    <= bus.cmd_rw;
            nack_q  <= 1'b0;
            bit_cnt <= '0;
            busy_q  <= 1'b1;
         end else if (rsp_valid_q) begin
            busy_q <= 1'b0;
         end
         if (end_slot && (state == ADDR || state == WDATA || state == RDATA))
            bit_cnt <= bit_cnt + 3'd1;
         if (end_slot && (state == ADDR || state == WDATA))
            sr <= {sr[6:0], 1'b0};
         if (end_slot && state == ACK1 && rw_q != I2C_RD)
            sr <= wdata_q;
         if (sample_stb && state == RDATA)
            sr <= {sr[6:0], bus.sda_i};
         if (sample_stb && (state == ACK1 || state == ACK2) && bus.sda_i != I2C_ACK)
            nack_q <= 1'b1;
         if (end_slot && state == STOP) begin
            rsp_valid_q <= 1'b1;
            rsp_nack_q  <= nack_q;
            rsp_rdata_q <= (rw_q == I2C_RD && !nack_q) ? sr : 8'h00;
         end
      end
   end

   assign bus.cmd_ready = (state == IDLE);
   assign bus.busy      = busy_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_nack  = rsp_nack_q;
   assign bus.scl_o     = scl;
   assign bus.sda_o     = sda_drv;
   assign bus.sda_oe    = sda_en;
   assign dbg_state     = state;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural slave and bus protocol monitor.
module tb_i2c_master_ctrl;
   import i2c_pkg::*;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_t dbg_state;
   int     cyc = 0;
   int     checks = 0;
   int     failures = 0;

   i2c_master_ctrl_if bif();

   i2c_master_ctrl #(.CLK_DIV(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bif),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Slave model configuration, written by the directed steps.
   logic       ack_addr = 1'b1;
   logic       ack_data = 1'b1;
   logic [7:0] rd_byte  = 8'h00;

   logic       slave_sda = 1'b1;
   logic       sda_line;
   assign sda_line  = (bif.sda_oe ? bif.sda_o : 1'b1) & slave_sda;
   assign bif.sda_i = sda_line;

   logic       prev_scl = 1'b1;
   logic       prev_bus = 1'b1;
   logic       prev_rst = 1'b1;
   state_t     prev_state = IDLE;
   int         bit_idx = 0;
   int         rsp_count = 0;
   logic [7:0] cap_addr = 8'h00;
   logic [7:0] cap_data = 8'h00;
   logic       cap_ack1 = 1'b0;
   logic       cap_b17  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slave + protocol monitor, sampled on the falling clock edge.
   always @(negedge clk) begin
      prev_scl   <= bif.scl_o;
      prev_bus   <= sda_line;
      prev_state <= dbg_state;
      prev_rst   <= rst;
      if (rst) begin
         slave_sda <= 1'b1;
         bit_idx   <= 0;
      end else begin
         if (prev_scl && bif.scl_o && !prev_rst &&
             !(dbg_state inside {START, STOP}) && !(prev_state inside {START, STOP}))
            check("sda_stable_scl_high", sda_line, prev_bus);
         if (bif.busy && !bif.rsp_valid)
            check("ready_low_while_busy", bif.cmd_ready, 1'b0);
         if (bif.rsp_valid) rsp_count <= rsp_count + 1;
         if (prev_scl && bif.scl_o && prev_bus && !sda_line) begin
            bit_idx <= 0;
         end else if (!prev_scl && bif.scl_o) begin
            if (bit_idx < 8)                       cap_addr <= {cap_addr[6:0], sda_line};
            else if (bit_idx == 8)                 cap_ack1 <= sda_line;
            else if (bit_idx >= 9 && bit_idx <= 16) cap_data <= {cap_data[6:0], sda_line};
            else if (bit_idx == 17)                cap_b17  <= sda_line;
            bit_idx <= bit_idx + 1;
         end else if (prev_scl && !bif.scl_o) begin
            if (bit_idx == 8)
               slave_sda <= !ack_addr;
            else if (bit_idx >= 9 && bit_idx <= 16)
               slave_sda <= (cap_addr[0] && ack_addr) ? rd_byte[16 - bit_idx] : 1'b1;
            else if (bit_idx == 17)
               slave_sda <= !(!cap_addr[0] && ack_addr && ack_data);
            else
               slave_sda <= 1'b1;
         end
         if (prev_scl && bif.scl_o && !prev_bus && sda_line) slave_sda <= 1'b1;
      end
   end

   task automatic send(input logic [6:0] a, input logic r, input logic [7:0] d, output int t_acc);
      int n;
      @(negedge clk);
      bif.cmd_valid = 1'b1;
      bif.cmd_addr  = a;
      bif.cmd_rw    = r;
      bif.cmd_wdata = d;
      n = 0;
      while (!bif.cmd_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", bif.cmd_ready, 1'b1);
      t_acc = cyc;
      @(posedge clk);
      #1 bif.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int t_rsp);
      int n;
      n = 0;
      @(negedge clk);
      while (!bif.rsp_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("rsp_seen", bif.rsp_valid, 1'b1);
      t_rsp = cyc;
   endtask

   initial begin
      int t_acc, t_rsp, t_rsp2, c0, n;
      bif.cmd_valid = 1'b0;
      bif.cmd_addr  = '0;
      bif.cmd_rw    = 1'b0;
      bif.cmd_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_cmd_ready", bif.cmd_ready, 1'b1);
      check("rst_busy", bif.busy, 1'b0);
      check("rst_rsp_valid", bif.rsp_valid, 1'b0);
      check("rst_rsp_rdata", bif.rsp_rdata, 8'h00);
      check("rst_rsp_nack", bif.rsp_nack, 1'b0);
      check("rst_scl", bif.scl_o, 1'b1);
      check("rst_sda_o", bif.sda_o, 1'b1);
      check("rst_sda_oe", bif.sda_oe, 1'b0);

      // Write 0x2A <- 0xC3, slave ACKs both bytes.
      ack_addr = 1'b1; ack_data = 1'b1;
      send(7'h2A, 1'b0, 8'hC3, t_acc);
      check("wr_busy_after_accept", bif.busy, 1'b1);
      wait_rsp(t_rsp);
      check("wr_latency", t_rsp - t_acc, 321);
      check("wr_addr_byte", cap_addr, 8'h54);
      check("wr_data_byte", cap_data, 8'hC3);
      check("wr_rsp_nack", bif.rsp_nack, 1'b0);
      check("wr_rsp_rdata", bif.rsp_rdata, 8'h00);
      check("wr_rsp_busy", bif.busy, 1'b1);
      check("wr_rsp_ready", bif.cmd_ready, 1'b1);
      @(negedge clk);
      check("wr_rsp_pulse_end", bif.rsp_valid, 1'b0);
      check("wr_busy_clear", bif.busy, 1'b0);
      check("idle_scl", bif.scl_o, 1'b1);
      check("idle_sda_oe", bif.sda_oe, 1'b0);

      // Read from 0x2A, slave returns 0x5A.
      rd_byte = 8'h5A;
      send(7'h2A, 1'b1, 8'hFF, t_acc);
      wait_rsp(t_rsp);
      check("rd_latency", t_rsp - t_acc, 321);
      check("rd_addr_byte", cap_addr, 8'h55);
      check("rd_bus_byte", cap_data, 8'h5A);
      check("rd_master_nack", cap_b17, 1'b1);
      check("rd_rsp_rdata", bif.rsp_rdata, 8'h5A);
      check("rd_rsp_nack", bif.rsp_nack, 1'b0);
      @(negedge clk);
      check("rd_rdata_held", bif.rsp_rdata, 8'h5A);

      // Reset in the middle of the write data byte.
      send(7'h2A, 1'b0, 8'h77, t_acc);
      n = 0;
      while (dbg_state != WDATA && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("reached_wdata", dbg_state, WDATA);
      repeat (22) @(negedge clk);
      c0 = rsp_count;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_scl", bif.scl_o, 1'b1);
      check("midrst_sda_oe", bif.sda_oe, 1'b0);
      check("midrst_ready", bif.cmd_ready, 1'b1);
      check("midrst_busy", bif.busy, 1'b0);
      check("midrst_rdata", bif.rsp_rdata, 8'h00);
      check("midrst_state", dbg_state, IDLE);
      rst = 1'b0;
      repeat (400) @(negedge clk);
      check("midrst_no_rsp", rsp_count, c0);

      // Address NACK: slave leaves SDA released.
      ack_addr = 1'b0;
      send(7'h11, 1'b0, 8'hA5, t_acc);
      wait_rsp(t_rsp);
      check("nack_latency", t_rsp - t_acc, 177);
      check("nack_addr_byte", cap_addr, 8'h22);
      check("nack_ack1_bus", cap_ack1, 1'b1);
      check("nack_rsp_nack", bif.rsp_nack, 1'b1);
      check("nack_rsp_rdata", bif.rsp_rdata, 8'h00);

      // Back-to-back: cmd_valid stays high across rsp_valid; fields change mid-flight.
      ack_addr = 1'b1; ack_data = 1'b1;
      @(negedge clk);
      bif.cmd_valid = 1'b1;
      bif.cmd_addr  = 7'h2A;
      bif.cmd_rw    = 1'b0;
      bif.cmd_wdata = 8'hC3;
      check("b2b_ready_first", bif.cmd_ready, 1'b1);
      t_acc = cyc;
      @(posedge clk);
      #1 bif.cmd_wdata = 8'h3C;
      bif.cmd_addr = 7'h15;
      wait_rsp(t_rsp);
      check("b2b_first_latency", t_rsp - t_acc, 321);
      check("b2b_first_data", cap_data, 8'hC3);
      check("b2b_first_addr", cap_addr, 8'h54);
      check("b2b_rsp_ready", bif.cmd_ready, 1'b1);
      check("b2b_rsp_busy", bif.busy, 1'b1);
      @(negedge clk);
      check("b2b_start_next", dbg_state, START);
      check("b2b_busy_held", bif.busy, 1'b1);
      check("b2b_ready_low", bif.cmd_ready, 1'b0);
      bif.cmd_valid = 1'b0;
      wait_rsp(t_rsp2);
      check("b2b_second_latency", t_rsp2 - t_rsp, 321);
      check("b2b_second_addr", cap_addr, 8'h2A);
      check("b2b_second_data", cap_data, 8'h3C);
      check("b2b_second_nack", bif.rsp_nack, 1'b0);

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
